bus_response_collector: RTL

//  CPU-side return path of the system bus, the counterpart of the address decoder.
//  - Latches the decoder's one-hot device select when a request is issued.
//  - Holds that select stable to the devices until the target signals done.
//  - Muxes the target's read data back to the CPU as a single-cycle ready pulse.
//  - Flags a bus error for unmapped addresses and, optionally, for unresponsive devices.

---
 rtl/bus_response_collector.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/bus_response_collector.sv
// CPU-side bus return path: latches the decoded device, waits for its done, returns one ready pulse.
// Optional watchdog on unresponsive devices is compiled in with `define BUS_TIMEOUT_EN.
module bus_response_collector #(
  parameter int NUM_DEV        = 7,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req,
  input  logic                      i_we,
  input  logic [NUM_DEV-1:0]        i_sel,
  input  logic [NUM_DEV-1:0]        i_done,
  input  logic [NUM_DEV*DATA_W-1:0] i_rdata,
  output logic [NUM_DEV-1:0]        o_dev_active,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_ready,
  output logic                      o_error,
  output logic                      o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [NUM_DEV-1:0] DEV_ONE = {{(NUM_DEV-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [NUM_DEV-1:0]  dev_q, dev_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   sel_data;
  logic                done_hit;

`ifdef BUS_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Keeps only the lowest set bit, so a malformed multi-hot select picks one device.
  function automatic logic [NUM_DEV-1:0] lowest_one(input logic [NUM_DEV-1:0] v);
    return v & (~v + DEV_ONE);
  endfunction

  // Read-data mux and done filter for the latched device only.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      sel_data = sel_data | (dev_q[k] ? i_rdata[k*DATA_W +: DATA_W] : {DATA_W{1'b0}});
    end
    done_hit = |(i_done & dev_q);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    dev_d   = dev_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    error_d = error_q;
    busy_d  = busy_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        error_d = 1'b0;
        busy_d  = 1'b0;
        dev_d   = '0;
        if (i_req) begin
          busy_d = 1'b1;
          if (|i_sel) begin
            state_d = S_WAIT;
            dev_d   = lowest_one(i_sel);
            we_d    = i_we;
`ifdef BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            // Unmapped address: answer immediately with an error.
            state_d = S_RESP;
            ready_d = 1'b1;
            error_d = 1'b1;
            rdata_d = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (done_hit) begin
          state_d = S_RESP;
          ready_d = 1'b1;
          error_d = 1'b0;
          dev_d   = '0;
          rdata_d = we_q ? {DATA_W{1'b0}} : sel_data;
        end else begin
`ifdef BUS_TIMEOUT_EN
          if (cnt_q == CNT_LAST) begin
            state_d = S_RESP;
            ready_d = 1'b1;
            error_d = 1'b1;
            dev_d   = '0;
            rdata_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        error_d = 1'b0;
        busy_d  = 1'b0;
        dev_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        error_d = 1'b0;
        busy_d  = 1'b0;
        dev_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      dev_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dev_q   <= dev_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
      busy_q  <= busy_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign o_dev_active = dev_q;
  assign o_rdata      = rdata_q;
  assign o_ready      = ready_q;
  assign o_error      = error_q;
  assign o_busy       = busy_q;

endmodule
